// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
// Control codes are also consumed by the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Fixed WIDTH-step latency; product is the low WIDTH bits.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  // Next accumulator value for the current step
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  // Load on start, step while running, clear count on abort
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_cnt    <= '0;
    end else if (start_i) begin
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (run_i) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign done_o    = run_i & ~flush_i & (r_cnt == LAST);
  assign product_o = w_acc_next;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR, iterative MUL.
// Stalls the pipeline while a multiply is in flight.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_single;
  logic             w_mul_run;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;
  logic [WIDTH-1:0] w_alu_res;

  assign w_accept    = (r_state == ST_IDLE) & valid_i & ~flush_i;
  assign w_is_mul    = (ALUCtrl_i == ALU_MUL);
  assign w_mul_start = w_accept & w_is_mul;
  assign w_single    = w_accept & ~w_is_mul;
  assign w_mul_run   = (r_state == ST_MUL);

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_mul_start),
    .run_i    (w_mul_run),
    .flush_i  (flush_i),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .done_o   (w_mul_done),
    .product_o(w_mul_prod)
  );

  // Single-cycle result; unknown codes yield zero
  always_comb begin
    w_alu_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: w_alu_res = data1_i + data2_i;
      ALU_SUB: w_alu_res = data1_i - data2_i;
      ALU_AND: w_alu_res = data1_i & data2_i;
      ALU_OR:  w_alu_res = data1_i | data2_i;
      default: w_alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: flush beats both accept and the final MUL step
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_mul_start) begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (flush_i || w_mul_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Handshake outputs follow the state
  always_comb begin
    ready_o = 1'b0;
    stall_o = 1'b0;
    unique case (r_state)
      ST_IDLE: ready_o = 1'b1;
      ST_MUL:  stall_o = 1'b1;
    endcase
  end

  // Result register: valid pulses, data holds between results
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_single | w_mul_done;
      if (w_single) begin
        r_data <= w_alu_res;
      end else if (w_mul_done) begin
        r_data <= w_mul_prod;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign zero_o  = (r_data == '0);

endmodule
